// File: rtl/ts_pkg.sv
// ts_pkg: shared TS constants, sync state encoding and position helper
package ts_pkg;
  localparam int         TS_PKT_LEN   = 188;
  localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
  typedef enum logic [1:0] {
    ST_SYNC_HUNT   = 2'd0,
    ST_SYNC_VERIFY = 2'd1,
    ST_SYNC_LOCKED = 2'd2
  } sync_st_e;
  // Byte position within a packet, wrapping at the last byte of the packet
  function automatic logic [7:0] pos_next(input logic [7:0] pos, input int len);
    return (pos == 8'(len - 1)) ? 8'd0 : pos + 8'd1;
  endfunction
endpackage

// File: rtl/ts_sat_counter.sv
// ts_sat_counter: statistics counter that sticks at all-ones instead of wrapping
module ts_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  // Count up on inc_i, hold once saturated; clr_i has priority
  always_ff @(posedge clk)
    if (clr_i) cnt_q <= '0;
    else if (inc_i && !(&cnt_q)) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/ts_sync_align.sv
// ts_sync_align: acquires TS packet alignment and forwards only whole sync-verified packets
module ts_sync_align
  import ts_pkg::*;
#(
  parameter int         PKT_LEN      = TS_PKT_LEN,
  parameter logic [7:0] SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 3,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       ts_in_d,
  input  logic             ts_in_wrreq,
  output logic [7:0]       ts_out_d,
  output logic             ts_out_wrreq,
  input  logic             ts_out_almost_full,
  input  logic             fifo_aclr,
  output logic             locked,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] sync_loss_cnt
);
  localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_COUNT);
  sync_st_e   st_q, st_d;
  logic [7:0] pos_q, pos_d;
  logic [7:0] good_q, good_d;
  logic [7:0] miss_q, miss_d;
  logic       fwd_q, fwd_d;
  logic       locked_q, locked_d;
  logic [7:0] out_d_q;
  logic       out_wr_q;
  logic       aclr_q;
  logic       flush, slot, sync_ok, clr;
  logic       inc_pkt, inc_drop, inc_loss;
  assign flush   = fifo_aclr && !aclr_q;
  assign clr     = !reset || flush;
  assign slot    = ts_in_wrreq && (pos_q == 8'd0);
  assign sync_ok = ts_in_d == SYNC_BYTE;
  // Delayed copy of fifo_aclr for rising-edge detection, tracked even in reset
  always_ff @(posedge clk)
    aclr_q <= fifo_aclr;
  // Sync state register; reset and flush both restart acquisition from HUNT
  always_ff @(posedge clk)
    st_q <= clr ? ST_SYNC_HUNT : st_d;
  // Next sync state, evaluated only on valid bytes
  always_comb begin
    st_d = st_q;
    if (ts_in_wrreq)
      unique case (st_q)
        ST_SYNC_HUNT:   st_d = sync_ok ? ST_SYNC_VERIFY : ST_SYNC_HUNT;
        ST_SYNC_VERIFY: st_d = !slot ? ST_SYNC_VERIFY : !sync_ok ? ST_SYNC_HUNT :
                               (good_q + 8'd1 == LOCK_N) ? ST_SYNC_LOCKED : ST_SYNC_VERIFY;
        ST_SYNC_LOCKED: st_d = (slot && !sync_ok && miss_q + 8'd1 == UNLOCK_N) ? ST_SYNC_HUNT : ST_SYNC_LOCKED;
        default:        st_d = ST_SYNC_HUNT;
      endcase
  end
  // Position, sync tallies, per-packet forward decision and statistics strobes
  always_comb begin
    pos_d    = pos_q;
    good_d   = good_q;
    miss_d   = miss_q;
    fwd_d    = fwd_q;
    locked_d = locked_q;
    inc_pkt  = 1'b0;
    inc_drop = 1'b0;
    inc_loss = 1'b0;
    if (ts_in_wrreq)
      unique case (st_q)
        ST_SYNC_HUNT: begin
          pos_d  = sync_ok ? 8'd1 : 8'd0;
          good_d = sync_ok ? 8'd1 : 8'd0;
        end
        ST_SYNC_VERIFY: begin
          pos_d = pos_next(pos_q, PKT_LEN);
          if (slot && !sync_ok) begin
            pos_d  = 8'd0;
            good_d = 8'd0;
          end else if (slot) begin
            good_d = good_q + 8'd1;
            if (good_d == LOCK_N) begin
              locked_d = 1'b1;
              fwd_d    = 1'b1;
              miss_d   = 8'd0;
              inc_pkt  = 1'b1;
            end
          end
        end
        ST_SYNC_LOCKED: begin
          pos_d = pos_next(pos_q, PKT_LEN);
          if (slot && sync_ok) begin
            miss_d   = 8'd0;
            fwd_d    = !ts_out_almost_full;
            inc_pkt  = !ts_out_almost_full;
            inc_drop = ts_out_almost_full;
          end else if (slot) begin
            miss_d   = miss_q + 8'd1;
            fwd_d    = 1'b0;
            inc_drop = 1'b1;
            if (miss_d == UNLOCK_N) begin
              pos_d    = 8'd0;
              good_d   = 8'd0;
              miss_d   = 8'd0;
              locked_d = 1'b0;
              inc_loss = 1'b1;
            end
          end
        end
        default: begin
          pos_d    = 8'd0;
          good_d   = 8'd0;
          miss_d   = 8'd0;
          fwd_d    = 1'b0;
          locked_d = 1'b0;
        end
      endcase
  end
  // Datapath registers and the single-cycle output stage
  always_ff @(posedge clk)
    if (clr) begin
      pos_q    <= 8'd0;
      good_q   <= 8'd0;
      miss_q   <= 8'd0;
      fwd_q    <= 1'b0;
      locked_q <= 1'b0;
      out_d_q  <= 8'd0;
      out_wr_q <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      fwd_q    <= fwd_d;
      locked_q <= locked_d;
      out_wr_q <= ts_in_wrreq && fwd_d;
      if (ts_in_wrreq) out_d_q <= ts_in_d;
    end
  ts_sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk   (clk),
    .clr_i (!reset),
    .inc_i (inc_pkt && reset && !flush),
    .cnt_o (pkt_cnt)
  );
  ts_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .clr_i (!reset),
    .inc_i (inc_drop && reset && !flush),
    .cnt_o (drop_cnt)
  );
  ts_sat_counter #(.W(CNT_W)) u_loss_cnt (
    .clk   (clk),
    .clr_i (!reset),
    .inc_i (inc_loss && reset && !flush),
    .cnt_o (sync_loss_cnt)
  );
  assign ts_out_d     = out_d_q;
  assign ts_out_wrreq = out_wr_q;
  assign locked       = locked_q;
endmodule

// File: tb/tb_ts_sync_align.sv
// tb_ts_sync_align: randomized scoreboard bench for ts_sync_align
module tb_ts_sync_align;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  ts_in_d = 8'd0;
  logic        ts_in_wrreq = 1'b0;
  logic [7:0]  ts_out_d;
  logic        ts_out_wrreq;
  logic        ts_out_almost_full = 1'b0;
  logic        fifo_aclr = 1'b0;
  logic        locked;
  logic [15:0] pkt_cnt, drop_cnt, sync_loss_cnt;
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  logic [7:0] exp_q[$];
  int m_st, m_pos, m_good, m_miss, m_pkt, m_drop, m_loss;
  bit m_fwd, m_aclr;

  ts_sync_align dut (
    .clk                (clk),
    .reset              (reset),
    .ts_in_d            (ts_in_d),
    .ts_in_wrreq        (ts_in_wrreq),
    .ts_out_d           (ts_out_d),
    .ts_out_wrreq       (ts_out_wrreq),
    .ts_out_almost_full (ts_out_almost_full),
    .fifo_aclr          (fifo_aclr),
    .locked             (locked),
    .pkt_cnt            (pkt_cnt),
    .drop_cnt           (drop_cnt),
    .sync_loss_cnt      (sync_loss_cnt)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int x);
    return x > 65535 ? 65535 : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: acts on the stream as the rules describe, byte by byte; queues expected output bytes
  task automatic model_step();
    bit fl, slot, ok;
    fl = fifo_aclr && !m_aclr;
    m_aclr = fifo_aclr;
    if (!reset) begin
      m_pkt = 0; m_drop = 0; m_loss = 0;
    end
    if (!reset || fl) begin
      m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_fwd = 0;
      return;
    end
    if (!ts_in_wrreq) return;
    ok = ts_in_d == 8'h47;
    if (m_st == 0) begin
      if (ok) begin m_st = 1; m_pos = 1; m_good = 1; end
      return;
    end
    slot = m_pos == 0;
    m_pos = (m_pos + 1) % 188;
    if (slot) begin
      if (m_st == 1) begin
        if (!ok) begin m_st = 0; m_pos = 0; m_good = 0; end
        else begin
          m_good = m_good + 1;
          if (m_good == 3) begin m_st = 2; m_fwd = 1; m_miss = 0; m_pkt = sat(m_pkt + 1); end
        end
      end else if (ok) begin
        m_miss = 0;
        m_fwd = !ts_out_almost_full;
        if (m_fwd) m_pkt = sat(m_pkt + 1); else m_drop = sat(m_drop + 1);
      end else begin
        m_fwd = 0;
        m_drop = sat(m_drop + 1);
        m_miss = m_miss + 1;
        if (m_miss == 3) begin
          m_st = 0; m_pos = 0; m_good = 0; m_miss = 0; m_loss = sat(m_loss + 1);
        end
      end
    end
    if (m_fwd) exp_q.push_back(ts_in_d);
  endtask

  task automatic cyc(input logic v, input logic [7:0] d);
    ts_in_wrreq = v;
    ts_in_d = d;
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] payload();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    return b == 8'h47 ? 8'h00 : b;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_locked"}, int'(locked), m_st == 2 ? 1 : 0);
    chk({tag, "_pkt_cnt"}, int'(pkt_cnt), m_pkt);
    chk({tag, "_drop_cnt"}, int'(drop_cnt), m_drop);
    chk({tag, "_loss_cnt"}, int'(sync_loss_cnt), m_loss);
  endtask

  // ev: 0 none, 1 back-pressure on, 2 back-pressure off, 3 reset pulse, 4 flush edge
  task automatic send_pkt(input logic [7:0] s, input int ev_at, input int ev);
    int keep;
    for (int i = 0; i < 188; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, payload());
      if (i == ev_at && ev == 1) ts_out_almost_full = 1'b1;
      if (i == ev_at && ev == 2) ts_out_almost_full = 1'b0;
      if (i == ev_at && (ev == 3 || ev == 4)) begin
        keep = int'(pkt_cnt);
        if (ev == 3) reset = 1'b0; else fifo_aclr = 1'b1;
        cyc(1'b1, payload());
        reset = 1'b1;
        fifo_aclr = 1'b0;
        chk("wrreq_after_clear", int'(ts_out_wrreq), 0);
        chk("locked_after_clear", int'(locked), 0);
        chk("pkt_cnt_after_clear", int'(pkt_cnt), ev == 3 ? 0 : keep);
        if (ev == 3) chk("loss_cnt_after_reset", int'(sync_loss_cnt), 0);
        if ($urandom_range(0, 1) == 1) cyc(1'b0, payload());
      end else cyc(1'b1, i == 0 ? s : payload());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'd0);
  endtask

  // Monitor: every output byte must be the next byte the reference expects
  always @(negedge clk)
    if (ts_out_wrreq) begin
      out_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra: got byte %02h expected no output", ts_out_d);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (ts_out_d !== e) begin
          errors++;
          $display("FAIL out_byte: got %02h expected %02h", ts_out_d, e);
        end
      end
    end

  initial begin
    int n0, p0, d0;
    m_aclr = 0;
    @(posedge clk);
    #1;
    idle(3);
    reset = 1'b1;
    chk("rst_wrreq", int'(ts_out_wrreq), 0);
    chk("rst_out_d", int'(ts_out_d), 0);
    check_model("rst");
    chk("rst_pkt_zero", int'(pkt_cnt), 0);

    n0 = out_cnt;
    for (int k = 0; k < 5; k++) send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t1_bytes", out_cnt - n0, 564);
    chk("t1_pkt_cnt", int'(pkt_cnt), 3);
    chk("t1_drop_cnt", int'(drop_cnt), 0);
    chk("t1_locked", int'(locked), 1);
    check_model("t1");

    reset = 1'b0;
    cyc(1'b0, 8'd0);
    reset = 1'b1;
    n0 = out_cnt;
    for (int i = 0; i < 10; i++) cyc(1'b1, i == 3 ? 8'h47 : payload());
    for (int k = 0; k < 5; k++) send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t2_pkt_cnt", int'(pkt_cnt), 2);
    chk("t2_bytes", out_cnt - n0, 376);
    check_model("t2");

    p0 = int'(pkt_cnt); d0 = int'(drop_cnt); n0 = out_cnt;
    send_pkt(8'h00, -1, 0);
    send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t3_drop_inc", int'(drop_cnt) - d0, 1);
    chk("t3_pkt_inc", int'(pkt_cnt) - p0, 1);
    chk("t3_locked", int'(locked), 1);
    chk("t3_bytes", out_cnt - n0, 188);
    check_model("t3");

    for (int k = 0; k < 3; k++) send_pkt(8'h00, -1, 0);
    chk("t4_locked", int'(locked), 0);
    chk("t4_loss", int'(sync_loss_cnt), 1);
    n0 = out_cnt;
    send_pkt(8'h47, -1, 0);
    send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t4_no_out", out_cnt - n0, 0);
    send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t4_relock_bytes", out_cnt - n0, 188);
    check_model("t4");

    p0 = int'(pkt_cnt); d0 = int'(drop_cnt); n0 = out_cnt;
    send_pkt(8'h47, 50, 1);
    send_pkt(8'h47, 100, 2);
    send_pkt(8'h47, -1, 0);
    idle(2);
    chk("t5_pkt_inc", int'(pkt_cnt) - p0, 2);
    chk("t5_drop_inc", int'(drop_cnt) - d0, 1);
    chk("t5_bytes", out_cnt - n0, 376);
    check_model("t5");

    send_pkt(8'h47, 90, 3);
    check_model("t6r");
    for (int k = 0; k < 4; k++) send_pkt(8'h47, -1, 0);
    check_model("t6r_relock");
    send_pkt(8'h47, 90, 4);
    check_model("t6f");
    for (int k = 0; k < 4; k++) send_pkt(8'h47, -1, 0);
    idle(3);
    check_model("t6f_relock");
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
